// File: rtl/adxl362_spi_master.sv
// adxl362_spi_master
// SPI mode-0 initiator for the ADXL362 register interface. It issues single-byte
// register writes (0x0A) and burst register reads (0x0B), MSB first, on one chip
// select. SCLK is derived from clk_16mhz, with CLK_DIV system cycles per half-period.
module adxl362_spi_master #(
    parameter int CLK_DIV   = 4,
    parameter int MAX_BURST = 8
) (
    input  logic       clk_16mhz,
    input  logic       reset,
    input  logic       start,
    input  logic       rw,
    input  logic [5:0] address,
    input  logic [3:0] length,
    input  logic [7:0] data_write,
    output logic       busy,
    output logic       done,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       sclk,
    output logic       cs_n,
    output logic       mosi,
    input  logic       miso
);

    localparam int DIV_W    = $clog2(CLK_DIV);
    localparam int MAX_BITS = MAX_BURST * 8 + 16;
    localparam int BIT_W    = $clog2(MAX_BITS);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [3:0]       BURST_MAX = 4'(MAX_BURST);
    localparam logic [7:0]       CMD_WRITE = 8'h0A;
    localparam logic [7:0]       CMD_READ  = 8'h0B;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [DIV_W-1:0] div_cnt;
    logic             phase;      // 0: sclk low half, 1: sclk high half
    logic [BIT_W-1:0] bit_cnt;
    logic [BIT_W-1:0] bit_last;
    logic             rw_q;
    logic [23:0]      tx_sr;
    logic [6:0]       rx_sr;

    logic             div_end;
    logic             rise_en;
    logic             fall_en;
    logic             last_bit;
    logic [3:0]       len_eff;
    logic [BIT_W-1:0] rd_last;

    // Half-period timing strobes, clamped burst length and next-state / pin outputs
    always_comb begin
        div_end    = (div_cnt == DIV_LAST);
        rise_en    = (state == SHIFT) && div_end && !phase;
        fall_en    = (state == SHIFT) && div_end && phase;
        last_bit   = (bit_cnt == bit_last);

        len_eff    = length;
        if (length == 4'd0) begin
            len_eff = 4'd1;
        end else if (length > BURST_MAX) begin
            len_eff = BURST_MAX;
        end
        // 16 header bits plus 8 per data byte, expressed as the index of the last bit
        rd_last    = BIT_W'({len_eff, 3'b000}) + BIT_W'(15);

        state_next = state;
        case (state)
            IDLE:    if (start)   state_next = SETUP;
            SETUP:   if (div_end) state_next = SHIFT;
            SHIFT:   if (fall_en && last_bit) state_next = HOLD;
            HOLD:    if (div_end) state_next = GAP;
            GAP:     if (div_end) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase

        busy = (state != IDLE);
        done = (state == DONE);
        cs_n = !((state == SETUP) || (state == SHIFT) || (state == HOLD));
        sclk = (state == SHIFT) && phase;
        mosi = ((state == SETUP) || (state == SHIFT)) ? tx_sr[23] : 1'b0;
    end

    // State register
    always_ff @(posedge clk_16mhz) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Request capture, SCLK divider, bit counting and the shift registers
    always_ff @(posedge clk_16mhz) begin
        if (reset) begin
            div_cnt  <= '0;
            phase    <= 1'b0;
            bit_cnt  <= '0;
            bit_last <= '0;
            rw_q     <= 1'b0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            case (state)
                IDLE: begin
                    div_cnt <= '0;
                    phase   <= 1'b0;
                    bit_cnt <= '0;
                    if (start) begin
                        rw_q     <= rw;
                        tx_sr    <= {rw ? CMD_READ : CMD_WRITE, 2'b00, address,
                                     rw ? 8'h00 : data_write};
                        bit_last <= rw ? rd_last : BIT_W'(23);
                    end
                end
                SHIFT: begin
                    div_cnt <= div_end ? '0 : div_cnt + 1'b1;
                    if (rise_en) begin
                        phase <= 1'b1;
                        rx_sr <= {rx_sr[5:0], miso};
                        // Last bit of each data byte of a read completes rd_data
                        if (rw_q && (bit_cnt >= BIT_W'(16)) && (bit_cnt[2:0] == 3'b111)) begin
                            rd_data  <= {rx_sr, miso};
                            rd_valid <= 1'b1;
                        end
                    end
                    if (fall_en) begin
                        phase <= 1'b0;
                        // Zeros shift in behind the header, so mosi is 0 in the read data phase
                        tx_sr <= {tx_sr[22:0], 1'b0};
                        if (!last_bit) begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                SETUP, HOLD, GAP: begin
                    div_cnt <= div_end ? '0 : div_cnt + 1'b1;
                    phase   <= 1'b0;
                end
                default: begin
                    div_cnt <= '0;
                    phase   <= 1'b0;
                end
            endcase
        end
    end

endmodule
